// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the program counter, issues single-word reads to
// instruction memory, latches the returned instruction and its PC, and raises
// sticky faults for misaligned fetches and memory timeouts.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_start,
    input  logic        pc_write_en,
    input  logic [31:0] pc_next,
    input  logic        fault_clear,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] current_instruction,
    output logic [31:0] pc,
    output logic [31:0] old_pc,
    output logic        fetch_done,
    output logic        busy,
    output logic        misaligned_fault,
    output logic        bus_error
);

    localparam logic [31:0] Nop      = 32'h0000_0013;
    localparam logic [7:0]  WaitLast = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StReq, StDone, StFault} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] old_pc_q, old_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        mis_q, mis_d;
    logic        bus_q, bus_d;

    // Next-state logic: PC is writable only while idle so mem_addr stays put during a request.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        old_pc_d   = old_pc_q;
        instr_d    = instr_q;
        wait_cnt_d = wait_cnt_q;
        mis_d      = mis_q;
        bus_d      = bus_q;
        unique case (state_q)
            StIdle: begin
                if (pc_write_en) begin
                    pc_d = pc_next;
                end
                // Alignment is judged on the PC before any same-edge write.
                if (fetch_start) begin
                    if (pc_q[1:0] == 2'b00) begin
                        state_d    = StReq;
                        wait_cnt_d = 8'd0;
                    end else begin
                        state_d = StFault;
                        mis_d   = 1'b1;
                    end
                end
            end
            StReq: begin
                // A ready response wins over the timeout on the last allowed cycle.
                if (mem_ready) begin
                    instr_d  = mem_rdata;
                    old_pc_d = pc_q;
                    state_d  = StDone;
                end else if (wait_cnt_q == WaitLast) begin
                    state_d = StFault;
                    bus_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            StFault: begin
                if (fault_clear) begin
                    state_d = StIdle;
                    mis_d   = 1'b0;
                    bus_d   = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset overrides everything, including a response arriving mid-request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            old_pc_q   <= 32'h0000_0000;
            instr_q    <= Nop;
            wait_cnt_q <= 8'd0;
            mis_q      <= 1'b0;
            bus_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            old_pc_q   <= old_pc_d;
            instr_q    <= instr_d;
            wait_cnt_q <= wait_cnt_d;
            mis_q      <= mis_d;
            bus_q      <= bus_d;
        end
    end

    assign mem_req             = (state_q == StReq);
    assign mem_addr            = pc_q;
    assign pc                  = pc_q;
    assign old_pc              = old_pc_q;
    assign current_instruction = instr_q;
    assign fetch_done          = (state_q == StDone);
    assign busy                = (state_q == StReq) || (state_q == StDone);
    assign misaligned_fault    = mis_q;
    assign bus_error           = bus_q;

    // The control FSM must never ask for a fetch and a PC write in the same idle cycle.
    no_start_with_pc_write : assert property (@(posedge clk) disable iff (reset)
        !((state_q == StIdle) && fetch_start && pc_write_en));

endmodule
